// File: rtl/sci_master_if.sv
// rtl/sci_master_if.sv - host request/response channel and SCI bus bundle for sci_master
interface sci_master_if #(
    parameter int NUM_PERIPHERALS = 1,
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int PID_WIDTH       = 8
);
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_wnr;
    logic [PID_WIDTH-1:0]       req_pid;
    logic [ADDR_WIDTH-1:0]      req_addr;
    logic [DATA_WIDTH-1:0]      req_wdata;
    logic                       rsp_valid;
    logic [1:0]                 rsp_err;
    logic [DATA_WIDTH-1:0]      rsp_rdata;
    logic [NUM_PERIPHERALS-1:0] sci_csn;
    logic                       sci_req;
    logic                       sci_ack;
    logic                       sci_resp;

    modport master (
        input  req_valid, req_wnr, req_pid, req_addr, req_wdata, sci_ack, sci_resp,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, sci_csn, sci_req
    );

    modport slave (
        output req_valid, req_wnr, req_pid, req_addr, req_wdata, sci_ack, sci_resp,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, sci_csn, sci_req
    );
endinterface

// File: rtl/sci_master.sv
// rtl/sci_master.sv - SCI bus master: single-beat host requests to serial write/read frames
// with ack timeout, ack-drop detection and peripheral index range checking.
module sci_master #(
    parameter int NUM_PERIPHERALS = 1,
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int PID_WIDTH       = 8
) (
    input  logic         clk,
    input  logic         rstn,
    sci_master_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BIT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_ACK_DROP = 2'd2;
    localparam logic [1:0] ERR_BAD_PID  = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        WAIT_ACK,
        RDATA,
        TAIL,
        DONE
    } state_t;

    state_t                     state;
    logic                       wnr;
    logic [ADDR_WIDTH-1:0]      addr_sr;
    logic [DATA_WIDTH-1:0]      wdata_sr;
    logic [DATA_WIDTH-1:0]      rdata_sr;
    logic [BIT_W-1:0]           bit_cnt;
    logic [CNT_W-1:0]           to_cnt;
    logic [PID_WIDTH-1:0]       pid;

    logic                       ready_q;
    logic                       rsp_valid_q;
    logic [1:0]                 rsp_err_q;
    logic [DATA_WIDTH-1:0]      rsp_rdata_q;
    logic [NUM_PERIPHERALS-1:0] csn_q;
    logic                       req_q;

    assign pid           = bus.req_pid;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.sci_csn   = csn_q;
    assign bus.sci_req   = req_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            wnr         <= 1'b0;
            addr_sr     <= '0;
            wdata_sr    <= '0;
            rdata_sr    <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= '0;
            csn_q       <= '1;
            req_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        if (int'(pid) >= NUM_PERIPHERALS) begin
                            // Out-of-range target: answer immediately, bus stays idle.
                            state       <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_BAD_PID;
                            rsp_rdata_q <= '0;
                        end else begin
                            state    <= CMD;
                            wnr      <= bus.req_wnr;
                            addr_sr  <= bus.req_addr;
                            wdata_sr <= bus.req_wdata;
                            csn_q    <= ~(NUM_PERIPHERALS'(1) << pid);
                            req_q    <= bus.req_wnr;
                        end
                    end
                end

                CMD: begin
                    req_q   <= addr_sr[0];
                    addr_sr <= addr_sr >> 1;
                    bit_cnt <= '0;
                    state   <= ADDR;
                end

                ADDR: begin
                    if (bit_cnt == BIT_W'(ADDR_WIDTH - 1)) begin
                        bit_cnt <= '0;
                        if (wnr) begin
                            req_q    <= wdata_sr[0];
                            wdata_sr <= wdata_sr >> 1;
                            state    <= WDATA;
                        end else begin
                            req_q  <= 1'b0;
                            to_cnt <= '0;
                            state  <= WAIT_ACK;
                        end
                    end else begin
                        req_q   <= addr_sr[0];
                        addr_sr <= addr_sr >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                WDATA: begin
                    if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt <= '0;
                        req_q   <= 1'b0;
                        to_cnt  <= '0;
                        state   <= WAIT_ACK;
                    end else begin
                        req_q    <= wdata_sr[0];
                        wdata_sr <= wdata_sr >> 1;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end
                end

                WAIT_ACK: begin
                    if (bus.sci_ack) begin
                        if (wnr) begin
                            state       <= DONE;
                            csn_q       <= '1;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_OK;
                            rsp_rdata_q <= '0;
                        end else begin
                            // Read bits enter at the MSB so bit 0 lands at position 0 after DATA_WIDTH captures.
                            rdata_sr <= DATA_WIDTH'(bus.sci_resp) << (DATA_WIDTH - 1);
                            bit_cnt  <= BIT_W'(1);
                            state    <= (DATA_WIDTH > 1) ? RDATA : TAIL;
                        end
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                        state       <= DONE;
                        csn_q       <= '1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_TIMEOUT;
                        rsp_rdata_q <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                RDATA: begin
                    if (!bus.sci_ack) begin
                        state       <= DONE;
                        csn_q       <= '1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_ACK_DROP;
                        rsp_rdata_q <= '0;
                    end else begin
                        rdata_sr <= (rdata_sr >> 1) | (DATA_WIDTH'(bus.sci_resp) << (DATA_WIDTH - 1));
                        if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                            state <= TAIL;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                TAIL: begin
                    state       <= DONE;
                    csn_q       <= '1;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= ERR_OK;
                    rsp_rdata_q <= rdata_sr;
                end

                DONE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    csn_q   <= '1;
                    req_q   <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sci_master.sv
// tb/tb_sci_master.sv - self-checking bench for sci_master against a cycle-level frame model
module tb_sci_master;
    localparam int NP = 2;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int PW = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    sci_master_if #(.NUM_PERIPHERALS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PID_WIDTH(PW)) bus ();

    sci_master #(
        .NUM_PERIPHERALS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO), .PID_WIDTH(PW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            wnr;
        int            pid;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            k;      // WAIT_ACK cycle index at which the slave first acks, -1 never
        int            drop;   // read bit index whose edge sees ack low, -1 none
        logic [DW-1:0] rdat;
    } txn_t;

    typedef struct {
        int            done_cyc;
        logic [1:0]    err;
        logic [DW-1:0] rdata;
        logic [NP-1:0] csn_done;
        logic [31:0]   req_bits;
        int            req_bad;
        int            csn_bad;
        int            ready_bad;
        int            pulses;
        int            waits;
    } obs_t;

    // Reference model: frame timing in cycles counted from the accept edge.
    function automatic bit is_bad(txn_t t);
        return t.pid >= NP;
    endfunction

    function automatic int wait_start(txn_t t);
        return t.wnr ? 2 + AW + DW : 2 + AW;
    endfunction

    function automatic bit acked(txn_t t);
        return t.k >= 0 && t.k <= TO;
    endfunction

    function automatic bit dropped(txn_t t);
        return !t.wnr && t.drop >= 1 && t.drop < DW;
    endfunction

    function automatic int exp_done(txn_t t);
        if (is_bad(t)) return 1;
        if (!acked(t)) return wait_start(t) + TO + 1;
        if (t.wnr) return wait_start(t) + t.k + 1;
        if (dropped(t)) return wait_start(t) + t.k + t.drop + 1;
        return wait_start(t) + t.k + DW + 1;
    endfunction

    function automatic logic [1:0] exp_err(txn_t t);
        if (is_bad(t)) return 2'd3;
        if (!acked(t)) return 2'd1;
        if (dropped(t)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [DW-1:0] exp_rdata(txn_t t);
        if (is_bad(t) || !acked(t) || t.wnr || dropped(t)) return '0;
        return t.rdat;
    endfunction

    function automatic logic exp_req(txn_t t, int c);
        bit frame[$];
        if (is_bad(t)) return 1'b0;
        frame.push_back(t.wnr);
        for (int i = 0; i < AW; i++) frame.push_back(t.addr[i]);
        if (t.wnr) for (int j = 0; j < DW; j++) frame.push_back(t.wdata[j]);
        if (c >= 1 && c <= frame.size()) return frame[c-1];
        return 1'b0;
    endfunction

    function automatic logic [NP-1:0] exp_csn(txn_t t, int c);
        logic [NP-1:0] v = '1;
        if (!is_bad(t) && c >= 1 && c < exp_done(t)) v[t.pid] = 1'b0;
        return v;
    endfunction

    function automatic logic slave_ack(txn_t t, int c);
        int s;
        if (is_bad(t) || t.k < 0) return 1'b0;
        s = wait_start(t) + t.k;
        if (c < s) return 1'b0;
        if (t.wnr) return c == s;
        if (c >= s + DW) return 1'b0;
        if (t.drop >= 1 && c >= s + t.drop) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic slave_resp(txn_t t, int c);
        if (!slave_ack(t, c) || t.wnr) return 1'b0;
        return t.rdat[c - (wait_start(t) + t.k)];
    endfunction

    // Drives one request from a negedge, plays the slave, records what the DUT did.
    // Returns at the negedge of the expected DONE cycle with req_valid low.
    task automatic run_txn(input txn_t t, output obs_t o);
        int done;
        done = exp_done(t);
        o = '{done_cyc: -1, err: 2'd0, rdata: '0, csn_done: '0, req_bits: '0,
              req_bad: 0, csn_bad: 0, ready_bad: 0, pulses: 0, waits: 0};
        bus.req_valid = 1'b1;
        bus.req_wnr   = t.wnr;
        bus.req_pid   = PW'(t.pid);
        bus.req_addr  = t.addr;
        bus.req_wdata = t.wdata;
        bus.sci_ack   = 1'b0;
        bus.sci_resp  = 1'b0;
        while (bus.req_ready !== 1'b1 && o.waits < 50) begin
            @(negedge clk);
            o.waits++;
        end
        for (int c = 1; c <= done; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.req_valid = 1'b0;
                bus.req_wnr   = ~t.wnr;
                bus.req_pid   = PW'($urandom);
                bus.req_addr  = AW'($urandom);
                bus.req_wdata = DW'($urandom);
            end
            if (bus.rsp_valid === 1'b1) begin
                o.pulses++;
                if (o.done_cyc < 0) begin
                    o.done_cyc = c;
                    o.err      = bus.rsp_err;
                    o.rdata    = bus.rsp_rdata;
                    o.csn_done = bus.sci_csn;
                end
            end
            if (c <= 32) o.req_bits[c-1] = bus.sci_req;
            if (c < done) begin
                if (bus.sci_req !== exp_req(t, c)) o.req_bad++;
                if (bus.sci_csn !== exp_csn(t, c)) o.csn_bad++;
            end
            if (bus.req_ready !== 1'b0) o.ready_bad++;
            bus.sci_ack  = slave_ack(t, c);
            bus.sci_resp = slave_resp(t, c);
        end
        bus.sci_ack  = 1'b0;
        bus.sci_resp = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_wnr = 1'b0; bus.req_pid = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.sci_ack = 1'b0; bus.sci_resp = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.sci_csn !== 2'b11) begin errors++; $display("FAIL reset_csn: got %b want 11", bus.sci_csn); end
        checks++; if (bus.sci_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.sci_req); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 2'd0) begin errors++; $display("FAIL reset_rsp_err: got %0d want 0", bus.rsp_err); end
        checks++; if (bus.rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 00", bus.rsp_rdata); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        rstn = 1'b1;
    endtask

    task automatic test_write();
        txn_t t; obs_t o;
        t = '{wnr: 1'b1, pid: 0, addr: 4'h9, wdata: 8'h3C, k: 3, drop: -1, rdat: '0};
        run_txn(t, o);
        checks++; if (o.req_bits[12:0] !== 13'b0011110010011) begin errors++; $display("FAIL write_frame: got %b want 0011110010011", o.req_bits[12:0]); end
        checks++; if (o.done_cyc !== 18) begin errors++; $display("FAIL write_latency: got %0d want 18", o.done_cyc); end
        checks++; if (o.err !== 2'd0) begin errors++; $display("FAIL write_err: got %0d want 0", o.err); end
        checks++; if (o.rdata !== 8'h00) begin errors++; $display("FAIL write_rdata: got %h want 00", o.rdata); end
        checks++; if (o.csn_done !== 2'b11) begin errors++; $display("FAIL write_csn_release: got %b want 11", o.csn_done); end
        checks++; if (o.csn_bad !== 0) begin errors++; $display("FAIL write_csn: %0d wrong cycles, want 0", o.csn_bad); end
    endtask

    task automatic test_read();
        txn_t t; obs_t o;
        t = '{wnr: 1'b0, pid: 1, addr: 4'h5, wdata: 8'h00, k: 2, drop: -1, rdat: 8'hA5};
        run_txn(t, o);
        checks++; if (o.rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata: got %h want a5", o.rdata); end
        checks++; if (o.err !== 2'd0) begin errors++; $display("FAIL read_err: got %0d want 0", o.err); end
        checks++; if (o.done_cyc !== 17) begin errors++; $display("FAIL read_latency: got %0d want 17", o.done_cyc); end
        checks++; if (o.csn_bad !== 0) begin errors++; $display("FAIL read_csn_select: %0d wrong cycles, want 0", o.csn_bad); end
        checks++; if (o.req_bad !== 0) begin errors++; $display("FAIL read_frame: %0d wrong cycles, want 0", o.req_bad); end
    endtask

    task automatic test_timeout();
        txn_t t; obs_t o;
        t = '{wnr: 1'b1, pid: 0, addr: 4'h3, wdata: 8'h5A, k: -1, drop: -1, rdat: '0};
        run_txn(t, o);
        checks++; if (o.done_cyc !== 2 + AW + DW + 17) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", o.done_cyc, 2 + AW + DW + 17); end
        checks++; if (o.err !== 2'd1) begin errors++; $display("FAIL timeout_err: got %0d want 1", o.err); end
        checks++; if (o.csn_done !== 2'b11) begin errors++; $display("FAIL timeout_csn: got %b want 11", o.csn_done); end
    endtask

    task automatic test_ack_drop();
        txn_t t; obs_t o;
        t = '{wnr: 1'b0, pid: 0, addr: 4'hC, wdata: 8'h00, k: 0, drop: 4, rdat: 8'hFF};
        run_txn(t, o);
        checks++; if (o.err !== 2'd2) begin errors++; $display("FAIL ackdrop_err: got %0d want 2", o.err); end
        checks++; if (o.rdata !== 8'h00) begin errors++; $display("FAIL ackdrop_rdata: got %h want 00", o.rdata); end
        checks++; if (o.csn_done !== 2'b11) begin errors++; $display("FAIL ackdrop_csn: got %b want 11", o.csn_done); end
        checks++; if (o.done_cyc !== 11) begin errors++; $display("FAIL ackdrop_latency: got %0d want 11", o.done_cyc); end
    endtask

    task automatic test_bad_pid();
        txn_t t; obs_t o;
        t = '{wnr: 1'b1, pid: NP, addr: 4'hF, wdata: 8'hFF, k: 0, drop: -1, rdat: '0};
        run_txn(t, o);
        checks++; if (o.done_cyc !== 1) begin errors++; $display("FAIL badpid_latency: got %0d want 1", o.done_cyc); end
        checks++; if (o.err !== 2'd3) begin errors++; $display("FAIL badpid_err: got %0d want 3", o.err); end
        checks++; if (o.csn_done !== 2'b11) begin errors++; $display("FAIL badpid_csn: got %b want 11", o.csn_done); end
        @(negedge clk);
        checks++; if (bus.sci_csn !== 2'b11 || bus.sci_req !== 1'b0) begin errors++; $display("FAIL badpid_bus_idle: csn %b req %b want 11 0", bus.sci_csn, bus.sci_req); end
    endtask

    task automatic test_reset_mid_frame();
        txn_t t; obs_t o;
        int g = 0;
        bus.req_valid = 1'b1; bus.req_wnr = 1'b1; bus.req_pid = 8'd1;
        bus.req_addr = 4'hA; bus.req_wdata = 8'h81;
        while (bus.req_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (bus.sci_csn !== 2'b11) begin errors++; $display("FAIL midreset_csn: got %b want 11", bus.sci_csn); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", bus.req_ready); end
        rstn = 1'b1;
        t = '{wnr: 1'b0, pid: 1, addr: 4'h6, wdata: 8'h00, k: 1, drop: -1, rdat: 8'h3E};
        run_txn(t, o);
        checks++; if (o.waits !== 0) begin errors++; $display("FAIL midreset_accept_wait: got %0d want 0", o.waits); end
        checks++; if (o.done_cyc !== exp_done(t) || o.pulses !== 1) begin errors++; $display("FAIL midreset_next_done: cycle %0d pulses %0d want %0d 1", o.done_cyc, o.pulses, exp_done(t)); end
        checks++; if (o.rdata !== 8'h3E || o.err !== 2'd0) begin errors++; $display("FAIL midreset_next_rsp: rdata %h err %0d want 3e 0", o.rdata, o.err); end
    endtask

    task automatic test_back_to_back();
        txn_t t; obs_t o;
        t = '{wnr: 1'b1, pid: 1, addr: 4'h1, wdata: 8'hC3, k: 0, drop: -1, rdat: '0};
        run_txn(t, o);
        t = '{wnr: 1'b1, pid: 0, addr: 4'hE, wdata: 8'h7F, k: 1, drop: -1, rdat: '0};
        run_txn(t, o);
        checks++; if (o.waits !== 1) begin errors++; $display("FAIL b2b_ready_gap: got %0d want 1", o.waits); end
        checks++; if (o.req_bad !== 0 || o.csn_bad !== 0) begin errors++; $display("FAIL b2b_frame: req %0d csn %0d bad cycles want 0 0", o.req_bad, o.csn_bad); end
        checks++; if (o.done_cyc !== exp_done(t)) begin errors++; $display("FAIL b2b_done: got %0d want %0d", o.done_cyc, exp_done(t)); end
    endtask

    task automatic test_random();
        txn_t t; obs_t o;
        int r;
        for (int n = 0; n < 30; n++) begin
            r       = int'($urandom_range(0, 9));
            t.pid   = (r == 0) ? 200 : ((r == 1) ? NP : ((r < 6) ? 0 : 1));
            t.wnr   = 1'($urandom);
            t.addr  = AW'($urandom);
            t.wdata = DW'($urandom);
            t.rdat  = DW'($urandom);
            t.k     = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            t.drop  = (!t.wnr && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, DW - 1)) : -1;
            run_txn(t, o);
            checks++; if (o.done_cyc !== exp_done(t)) begin errors++; $display("FAIL rnd%0d_done: got %0d want %0d", n, o.done_cyc, exp_done(t)); end
            checks++; if (o.err !== exp_err(t)) begin errors++; $display("FAIL rnd%0d_err: got %0d want %0d", n, o.err, exp_err(t)); end
            checks++; if (o.rdata !== exp_rdata(t)) begin errors++; $display("FAIL rnd%0d_rdata: got %h want %h", n, o.rdata, exp_rdata(t)); end
            checks++; if (o.req_bad !== 0) begin errors++; $display("FAIL rnd%0d_frame: %0d wrong cycles want 0", n, o.req_bad); end
            checks++; if (o.csn_bad !== 0 || o.csn_done !== 2'b11) begin errors++; $display("FAIL rnd%0d_csn: %0d wrong cycles, at done %b want 0 11", n, o.csn_bad, o.csn_done); end
            checks++; if (o.ready_bad !== 0) begin errors++; $display("FAIL rnd%0d_ready: %0d busy cycles with ready high want 0", n, o.ready_bad); end
            checks++; if (o.pulses !== 1) begin errors++; $display("FAIL rnd%0d_pulses: got %0d want 1", n, o.pulses); end
            checks++; if (o.waits !== 1) begin errors++; $display("FAIL rnd%0d_ready_gap: got %0d want 1", n, o.waits); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_drop();
        test_bad_pid();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
